// File: rtl/dm_cache_if.sv
// rtl/dm_cache_if.sv - CPU load/store port and ram handshake bundle for dm_cache_ctrl
interface dm_cache_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_ready;
  logic              cpu_ack;
  logic [31:0]       cpu_rdata;

  logic [31:0]       mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic              mem_response;
  logic [31:0]       mem_out;

  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_response, mem_out,
    input  cpu_ready, cpu_ack, cpu_rdata, mem_data, mem_addr, mem_wr, hit_cnt, miss_cnt
  );

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_response, mem_out,
    output cpu_ready, cpu_ack, cpu_rdata, mem_data, mem_addr, mem_wr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-through no-write-allocate cache controller
// Read hits are served locally; read misses and all stores go through the change-triggered ram handshake.
module dm_cache_ctrl #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  dm_cache_if.slave  bus
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM} state_t;

  state_t            state_q, state_d;
  logic              req_wr_q, req_wr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic              hit_q, hit_d;
  logic              wait_q, wait_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wr_q, mem_wr_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [TAG_W-1:0]  tag_arr_q  [LINES];
  logic [31:0]       data_arr_q [LINES];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              lookup_hit;
  logic              arr_we;
  logic [31:0]       arr_wdata;

  assign req_idx    = req_addr_q[IDX_W-1:0];
  assign req_tag    = req_addr_q[ADDR_W-1:IDX_W];
  assign lookup_hit = valid_q[req_idx] && (tag_arr_q[req_idx] == req_tag);

  always_comb begin
    state_d     = state_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    hit_d       = hit_q;
    wait_d      = wait_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_data_d  = mem_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wr_d    = mem_wr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    valid_d     = valid_q;
    arr_we      = 1'b0;
    arr_wdata   = req_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          req_wr_d    = bus.cpu_wr;
          req_addr_d  = bus.cpu_addr;
          req_wdata_d = bus.cpu_wdata;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = lookup_hit;
        if (lookup_hit) begin
          hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
        end else begin
          miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
        end
        if (!req_wr_q && lookup_hit) begin
          cpu_rdata_d = data_arr_q[req_idx];
          cpu_ack_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          mem_addr_d = req_addr_q;
          mem_wr_d   = req_wr_q;
          mem_data_d = req_wr_q ? req_wdata_q : 32'd0;
          wait_d     = 1'b0;
          state_d    = MEM;
        end
      end
      MEM: begin
        wait_d = 1'b1;
        // response is stale until ram has seen at least two falling edges
        if (wait_q && bus.mem_response) begin
          cpu_ack_d = 1'b1;
          state_d   = IDLE;
          if (!req_wr_q) begin
            cpu_rdata_d      = bus.mem_out;
            valid_d[req_idx] = 1'b1;
            arr_we           = 1'b1;
            arr_wdata        = bus.mem_out;
          end else if (hit_q) begin
            arr_we = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= 32'd0;
      hit_q       <= 1'b0;
      wait_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 32'd0;
      mem_data_q  <= 32'd0;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      hit_cnt_q   <= 16'd0;
      miss_cnt_q  <= 16'd0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      hit_q       <= hit_d;
      wait_q      <= wait_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_data_q  <= mem_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      valid_q     <= valid_d;
    end
  end

  // Tag is rewritten on a write hit too; it is unchanged there, which keeps one write port.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_arr_q[req_idx]  <= req_tag;
      data_arr_q[req_idx] <= arr_wdata;
    end
  end

  assign bus.cpu_ready = (state_q == IDLE);
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - randomized bench for dm_cache_ctrl against a cache/memory reference model
module tb_dm_cache_ctrl;
  localparam int LINES  = 16;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dm_cache_if #(.ADDR_W(ADDR_W)) bus();

  dm_cache_ctrl #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h25) return 32'hDEADBEEF;
    return (i * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  // Behavioural ram: change-triggered, response updated on falling edges, optional extra stall.
  logic [31:0] ram_mem [256];
  logic [64:0] ram_last;
  int          ram_busy;
  int          ram_extra = 0;
  bit          ram_started = 1'b0;

  always @(negedge clk) begin
    if (!ram_started) begin
      for (int i = 0; i < 256; i++) ram_mem[i] = init_word(i);
      ram_started = 1'b1;
      ram_last = {bus.mem_wr, bus.mem_addr, bus.mem_data};
      ram_busy = 0;
      bus.mem_response <= 1'b1;
      bus.mem_out <= ram_mem[0];
    end else if ({bus.mem_wr, bus.mem_addr, bus.mem_data} !== ram_last) begin
      ram_last = {bus.mem_wr, bus.mem_addr, bus.mem_data};
      ram_busy = ram_extra + 1;
      bus.mem_response <= 1'b0;
    end else if (ram_busy > 0) begin
      ram_busy = ram_busy - 1;
      if (ram_busy == 0) begin
        if (bus.mem_wr) ram_mem[bus.mem_addr[7:0]] = bus.mem_data;
        else bus.mem_out <= ram_mem[bus.mem_addr[7:0]];
        bus.mem_response <= 1'b1;
      end
    end
  end

  // Reference model: cache contents as plain arrays, memory image, counters, last ram request.
  logic        ref_valid [LINES];
  logic [31:0] ref_tag   [LINES];
  logic [31:0] ref_data  [LINES];
  logic [31:0] ref_mem   [256];
  int          ref_hits, ref_misses;
  logic        exp_mem_wr;
  logic [31:0] exp_mem_addr, exp_mem_data, exp_rdata_last;

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    ref_hits = 0;
    ref_misses = 0;
    exp_mem_wr = 1'b0;
    exp_mem_addr = 32'd0;
    exp_mem_data = 32'd0;
    exp_rdata_last = 32'd0;
  endtask

  task automatic do_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input int extra);
    int          idx;
    logic        hit;
    logic        changed;
    int          exp_lat;
    int          lat;
    logic        ack;
    logic [31:0] new_data;
    idx = int'(addr % LINES);
    hit = ref_valid[idx] && (ref_tag[idx] == addr / LINES);
    if (hit) begin
      if (ref_hits < 65535) ref_hits++;
    end else begin
      if (ref_misses < 65535) ref_misses++;
    end
    if (!wr && hit) begin
      exp_lat = 1;
      exp_rdata_last = ref_data[idx];
    end else begin
      new_data = wr ? wdata : 32'd0;
      changed = {wr, addr, new_data} != {exp_mem_wr, exp_mem_addr, exp_mem_data};
      exp_lat = changed ? 3 + extra : 3;
      exp_mem_wr = wr;
      exp_mem_addr = addr;
      exp_mem_data = new_data;
      if (wr) begin
        ref_mem[addr[7:0]] = wdata;
        if (hit) ref_data[idx] = wdata;
      end else begin
        exp_rdata_last = ref_mem[addr[7:0]];
        ref_valid[idx] = 1'b1;
        ref_tag[idx] = addr / LINES;
        ref_data[idx] = ref_mem[addr[7:0]];
      end
    end

    ram_extra = extra;
    bus.cpu_req = 1'b1;
    bus.cpu_wr = wr;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wdata;
    @(posedge clk);
    #1;
    // a stray request while busy must be ignored
    bus.cpu_req = 1'($urandom_range(0, 1));
    bus.cpu_wr = 1'($urandom_range(0, 1));
    bus.cpu_addr = 32'($urandom_range(0, 63));
    bus.cpu_wdata = $urandom;
    lat = 0;
    ack = 1'b0;
    while (!ack && lat < 40) begin
      @(posedge clk);
      #1;
      bus.cpu_req = 1'b0;
      lat++;
      ack = bus.cpu_ack;
      if (!ack) check("busy_ready", 32'(bus.cpu_ready), 32'd0);
    end
    check("latency", lat, exp_lat);
    check("ack_ready", 32'(bus.cpu_ready), 32'd1);
    check("rdata", bus.cpu_rdata, exp_rdata_last);
    check("mem_addr", bus.mem_addr, exp_mem_addr);
    check("mem_wr", 32'(bus.mem_wr), 32'(exp_mem_wr));
    check("mem_data", bus.mem_data, exp_mem_data);
    check("hit_cnt", 32'(bus.hit_cnt), ref_hits);
    check("miss_cnt", 32'(bus.miss_cnt), ref_misses);
    @(posedge clk);
    #1;
    check("ack_single", 32'(bus.cpu_ack), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(bus.cpu_ready), 32'd1);
    check({tag, "_ack"}, 32'(bus.cpu_ack), 32'd0);
    check({tag, "_rdata"}, bus.cpu_rdata, 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_mem_data"}, bus.mem_data, 32'd0);
    check({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
    check({tag, "_hit_cnt"}, 32'(bus.hit_cnt), 32'd0);
    check({tag, "_miss_cnt"}, 32'(bus.miss_cnt), 32'd0);
  endtask

  initial begin
    bus.cpu_req = 1'b0;
    bus.cpu_wr = 1'b0;
    bus.cpu_addr = 32'd0;
    bus.cpu_wdata = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values("reset");

    do_op(1'b0, 32'h00, 32'd0, 0);
    check("first_read_miss_cnt", 32'(bus.miss_cnt), 32'd1);

    do_op(1'b0, 32'h25, 32'd0, 0);
    check("read_miss_data", bus.cpu_rdata, 32'hDEADBEEF);
    do_op(1'b0, 32'h25, 32'd0, 0);
    check("read_hit_cnt", 32'(bus.hit_cnt), 32'd1);

    do_op(1'b0, 32'h05, 32'd0, 0);
    do_op(1'b0, 32'h15, 32'd0, 0);
    do_op(1'b0, 32'h05, 32'd0, 0);

    do_op(1'b1, 32'h25, 32'h12345678, 0);
    check("write_hit_ram", ram_mem[8'h25], 32'h12345678);
    do_op(1'b0, 32'h25, 32'd0, 0);
    check("write_hit_readback", bus.cpu_rdata, 32'h12345678);

    do_op(1'b1, 32'h40, 32'hCAFEF00D, 0);
    do_op(1'b0, 32'h40, 32'd0, 0);
    check("write_miss_readback", bus.cpu_rdata, 32'hCAFEF00D);

    // reset while a read miss sits in MEM
    bus.cpu_req = 1'b1;
    bus.cpu_wr = 1'b0;
    bus.cpu_addr = 32'h3A;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("mid_mem_reset");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_no_ack", 32'(bus.cpu_ack), 32'd0);
    end
    rst = 1'b0;
    do_op(1'b0, 32'h3A, 32'd0, 0);
    check("after_reset_miss_cnt", 32'(bus.miss_cnt), 32'd1);

    for (int n = 0; n < 300; n++) begin
      do_op(1'($urandom_range(0, 2) == 0), 32'($urandom_range(0, 63)), $urandom,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
